uart_frame_tx: RTL and testbench
================================

# uart_frame_tx

Framed UART transmitter for the FPGA-to-host direction of the VISIO link. It buffers result bytes from the CNN datapath in a small FIFO and, on a Send request, emits one frame on the UART line. The frame is SOF, LEN, the payload, then CHK, 8N1 at CLK_BIT clocks per bit. It is the transmit counterpart of the host-to-FPGA frame path and drives the board's UART TX pin directly.

## Interface
- CLK_BIT, 10'd868: clock cycles per UART bit (115200 baud at 100 MHz); legal range 2..1023.
- FIFO_DEPTH, 16: payload FIFO entries; power of two, 2..256.
- SOF, 8'hA5: start-of-frame byte.
- CLK  in  1  system clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- WrEn  in  1  push WrByte into the FIFO this cycle.
- WrByte  in  8  payload byte.
- Full  out  1  FIFO full; writes while high are dropped.
- Send  in  1  request transmission of all bytes currently in the FIFO.
- Tx  out  1  UART serial output, idle high.
- Busy  out  1  frame in progress.
- Done  out  1  single-cycle pulse at frame completion.

## Operation
- Reset values: Tx=1, Busy=0, Done=0, Full=0, FIFO empty, frame FSM in IDLE, serializer in IDLE.
- Frame FSM states: IDLE -> SOF -> LEN -> DATA -> CHK -> IDLE.
- Send is accepted only in IDLE with the FIFO non-empty.
  - On acceptance, LEN is latched as the FIFO occupancy (1..FIFO_DEPTH).
  - Send while Busy is ignored.
  - Send with the FIFO empty is ignored: no frame, no Done.
- DATA pops exactly LEN bytes, oldest first, one pop per byte at serializer load.
- CHK = (LEN + sum of payload bytes) mod 256.
- Writes during a frame are accepted when not Full. They stay in the FIFO for the next frame and never alter the latched LEN.
- A simultaneous push and pop in one cycle performs both; occupancy is unchanged, and Full is evaluated after both.
- Full = (occupancy == FIFO_DEPTH). Write pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- FIFO_DEPTH=256 gives LEN=256, which is transmitted as 8'h00; hosts treat 0 as 256.
- Serializer sends 8N1, LSB first: start bit 0, 8 data bits, stop bit 1.
- Reset asserted mid-frame: Tx goes high immediately (asynchronously), the FIFO is emptied, Busy=0, and no Done pulse is produced.

## Timing
- Send sampled high in IDLE at edge N: Busy=1 and Tx=0 (SOF start bit) from edge N+1.
- Each bit is held exactly CLK_BIT cycles; each byte occupies 10*CLK_BIT cycles.
- Consecutive bytes within a frame are back-to-back: the next start bit begins the cycle after the previous stop bit ends, with no idle gap.
- Frame duration from edge N+1: (LEN+3)*10*CLK_BIT cycles.
- Busy falls and Done pulses high for one cycle on the edge the final stop bit ends. Tx stays 1.
- A new Send is accepted on the same edge Done is high. The next start bit then follows with zero gap.
- Full updates the cycle after the push that fills the FIFO.
- Full falls the cycle after the first pop from a full FIFO.

## Configuration
- UART_FRAME_CHK_EN defined: CHK byte is appended; frame length is LEN+3 bytes.
- UART_FRAME_CHK_EN undefined: the CHK state and checksum adder are removed.
  - The FSM goes DATA -> IDLE.
  - Frame length is LEN+2 bytes; duration (LEN+2)*10*CLK_BIT.

## Structure
- Shared package uart_frame_pkg holds:
  - frame FSM state encodings (IDLE, SOF, LEN, DATA, CHK);
  - serializer state encodings (IDLE, START, DATA, STOP);
  - default SOF 8'hA5 and default CLK_BIT 10'd868.
- One sub-module, uart_tx_serial: byte-load/ready handshake, baud counter, bit counter, 8N1 shift.
- The frame FSM, FIFO and checksum stay in uart_frame_tx.

## Test plan
Use CLK_BIT=4, FIFO_DEPTH=4.
- Reset, no stimulus -> Tx=1, Busy=0, Done=0 and Full=0 for 100 cycles.
- Push 8'h01, 8'h02, then pulse Send -> line decodes to A5 02 01 02 05.
  - Each bit is 4 cycles; Busy lasts 200 cycles; Done pulses once.
- Pulse Send with the FIFO empty -> Tx stays 1, Busy stays 0, no Done.
- Push 5 bytes 8'h10..8'h14 -> Full=1 after the 4th push; 8'h14 is dropped.
  - Send then yields A5 04 10 11 12 13 4A.
- Push 8'hFF, Send, then push 8'h33 mid-frame; Send again on the Done cycle.
  - First frame: A5 01 FF 00. Second frame: A5 01 33 34, with zero idle gap between frames.
- Assert Reset mid-payload -> Tx=1 in the same cycle, Busy=0, Full=0; a later Send with the FIFO empty produces nothing.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared encodings and defaults for the framed UART transmitter.
package uart_frame_pkg;

  typedef enum logic [2:0] {FrIdle, FrSof, FrLen, FrData, FrChk} frame_state_e;

  typedef enum logic [1:0] {SerIdle, SerStart, SerData, SerStop} ser_state_e;

  localparam logic [7:0] DefaultSof    = 8'hA5;
  localparam logic [9:0] DefaultClkBit = 10'd868;

endpackage

// File: rtl/uart_tx_serial.sv
// 8N1 byte serializer with load/ready handshake; ready also asserts in the last
// stop-bit cycle so a queued byte follows with no idle gap.
module uart_tx_serial
  import uart_frame_pkg::*;
#(
  parameter logic [9:0] CLK_BIT = DefaultClkBit
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  ser_state_e  state_q, state_d;
  logic [9:0]  baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (baud_q == CLK_BIT - 10'd1);
  assign ready   = (state_q == SerIdle) || ((state_q == SerStop) && bit_end);
  assign tx      = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == SerIdle) ? 10'd0 : baud_q + 10'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      SerIdle: begin
        if (load) begin
          state_d = SerStart;
          shift_d = data;
          tx_d    = 1'b0;
        end
      end
      SerStart: begin
        if (bit_end) begin
          state_d = SerData;
          baud_d  = 10'd0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      SerData: begin
        if (bit_end) begin
          baud_d = 10'd0;
          if (bit_q == 3'd7) begin
            state_d = SerStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      SerStop: begin
        if (bit_end) begin
          baud_d = 10'd0;
          if (load) begin
            state_d = SerStart;
            shift_d = data;
            tx_d    = 1'b0;
          end else begin
            state_d = SerIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = SerIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SerIdle;
      baud_q  <= 10'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Framed UART transmitter: payload FIFO plus SOF/LEN/payload[/CHK] frame FSM.
// Define UART_FRAME_CHK_EN to append the checksum byte.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter logic [9:0]  CLK_BIT    = DefaultClkBit,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SOF        = DefaultSof
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       WrEn,
  input  logic [7:0] WrByte,
  output logic       Full,
  input  logic       Send,
  output logic       Tx,
  output logic       Busy,
  output logic       Done
);

  localparam int unsigned   PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] CntOne   = (PtrW + 1)'(1);

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic [7:0]      rd_data;
  logic            push, pop;

  frame_state_e    state_q, state_d;
  logic [PtrW:0]   len_q, len_d;
  logic [PtrW:0]   rem_q, rem_d;
  logic            ser_load, ser_ready, accept, can_start;
  logic [7:0]      ser_byte;
`ifdef UART_FRAME_CHK_EN
  logic [7:0]      sum_q, sum_d;
`endif

  assign Full    = (count_q == DepthCnt);
  assign push    = WrEn && !Full;
  assign rd_data = mem[rd_ptr_q];
  assign accept  = Send && (count_q != '0);
  assign Busy    = (state_q != FrIdle);

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= WrByte;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + CntOne;
      else if (pop && !push) count_q <= count_q - CntOne;
    end
  end

  // Each state names the byte currently on the line; transitions fire when the
  // serializer can take the next byte, so bytes stream back-to-back.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    ser_load  = 1'b0;
    ser_byte  = SOF;
    pop       = 1'b0;
    Done      = 1'b0;
    can_start = 1'b0;
`ifdef UART_FRAME_CHK_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      FrIdle: can_start = 1'b1;
      FrSof: begin
        if (ser_ready) begin
          ser_load = 1'b1;
          ser_byte = 8'(len_q);
          state_d  = FrLen;
        end
      end
      FrLen, FrData: begin
        if (ser_ready) begin
          if (rem_q != '0) begin
            ser_load = 1'b1;
            ser_byte = rd_data;
            pop      = 1'b1;
            rem_d    = rem_q - CntOne;
            state_d  = FrData;
`ifdef UART_FRAME_CHK_EN
            sum_d    = sum_q + rd_data;
`endif
          end else begin
`ifdef UART_FRAME_CHK_EN
            ser_load = 1'b1;
            ser_byte = sum_q;
            state_d  = FrChk;
`else
            Done      = 1'b1;
            state_d   = FrIdle;
            can_start = 1'b1;
`endif
          end
        end
      end
`ifdef UART_FRAME_CHK_EN
      FrChk: begin
        if (ser_ready) begin
          Done      = 1'b1;
          state_d   = FrIdle;
          can_start = 1'b1;
        end
      end
`endif
      default: state_d = FrIdle;
    endcase

    // A Send coinciding with Done chains the next frame with no idle gap.
    if (can_start && accept) begin
      ser_load = 1'b1;
      ser_byte = SOF;
      state_d  = FrSof;
      len_d    = count_q;
      rem_d    = count_q;
`ifdef UART_FRAME_CHK_EN
      sum_d    = 8'(count_q);
`endif
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= FrIdle;
      len_q   <= '0;
      rem_q   <= '0;
`ifdef UART_FRAME_CHK_EN
      sum_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
`ifdef UART_FRAME_CHK_EN
      sum_q   <= sum_d;
`endif
    end
  end

  uart_tx_serial #(
    .CLK_BIT (CLK_BIT)
  ) u_serial (
    .clk   (CLK),
    .rst   (Reset),
    .load  (ser_load),
    .data  (ser_byte),
    .ready (ser_ready),
    .tx    (Tx)
  );

endmodule

// File: tb/tb_uart_frame_tx.sv
// Self-checking bench for uart_frame_tx with a frame-level reference model.
module tb_uart_frame_tx;

  localparam int BitCyc  = 4;
  localparam int ByteCyc = 10 * BitCyc;
  localparam int Depth   = 4;
`ifdef UART_FRAME_CHK_EN
  localparam int ChkBytes = 1;
`else
  localparam int ChkBytes = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_byte = 8'd0;
  logic       send = 1'b0;
  logic       full, tx, busy, done;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int txlow_cnt = 0;

  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_fifo[$];
  int exp_busy, exp_done, b0, d0, t0;

  uart_frame_tx #(
    .CLK_BIT    (10'd4),
    .FIFO_DEPTH (Depth),
    .SOF        (8'hA5)
  ) dut (
    .CLK    (clk),
    .Reset  (rst),
    .WrEn   (wr_en),
    .WrByte (wr_byte),
    .Full   (full),
    .Send   (send),
    .Tx     (tx),
    .Busy   (busy),
    .Done   (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (tx !== 1'b1) txlow_cnt <= txlow_cnt + 1;
  end

  // Line decoder: samples each bit mid-cell, records byte value and start cycle.
  initial begin
    logic [7:0] b;
    int st;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        st = cyc;
        repeat (BitCyc / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BitCyc) @(negedge clk);
          b[i] = tx;
        end
        repeat (BitCyc) @(negedge clk);
        rx_q.push_back(b);
        rx_t.push_back(st);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is SOF, LEN, all queued bytes, then optional sum.
  task automatic model_send();
    int n;
    logic [7:0] sum;
    n = m_fifo.size();
    if (n != 0) begin
      sum = n[7:0];
      exp_q.push_back(8'hA5);
      exp_q.push_back(n[7:0]);
      for (int i = 0; i < n; i++) begin
        sum = sum + m_fifo[0];
        exp_q.push_back(m_fifo.pop_front());
      end
      if (ChkBytes != 0) exp_q.push_back(sum);
      exp_busy += (n + 2 + ChkBytes) * ByteCyc;
      exp_done += 1;
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    wr_byte = b;
    if (m_fifo.size() < Depth) m_fifo.push_back(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic send_pulse();
    send = 1'b1;
    model_send();
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic scenario_begin();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    exp_busy = 0;
    exp_done = 0;
    b0 = busy_cnt;
    d0 = done_cnt;
  endtask

  task automatic scenario_end(input string tag);
    int g;
    g = 0;
    while (busy === 1'b1 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check({tag, "_idle_in_time"}, (g < 5000), 1);
    repeat (2) @(negedge clk);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < rx_q.size()) ? {24'd0, rx_q[i]} : 32'hDEAD_BEEF, {24'd0, exp_q[i]});
    end
    check({tag, "_busy_cycles"}, busy_cnt - b0, exp_busy);
    check({tag, "_done_pulses"}, done_cnt - d0, exp_done);
  endtask

  initial begin
    int bad, g, n;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_full", full, 0);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || full !== 1'b0) bad++;
    end
    check("idle_100_cycles", bad, 0);

    // Two-byte frame
    scenario_begin();
    push(8'h01);
    push(8'h02);
    send_pulse();
    scenario_end("two_bytes");

    // Send with the FIFO empty
    scenario_begin();
    t0 = txlow_cnt;
    send_pulse();
    repeat (100) @(negedge clk);
    scenario_end("empty_send");
    check("empty_send_tx_low", txlow_cnt - t0, 0);

    // Fill to full, extra byte dropped
    scenario_begin();
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i));
      check($sformatf("full_after_push%0d", i), full, (m_fifo.size() == Depth));
    end
    send_pulse();
    scenario_end("full_frame");

    // Mid-frame write, chained Send on the Done cycle
    scenario_begin();
    push(8'hFF);
    send_pulse();
    repeat (10) @(negedge clk);
    push(8'h33);
    g = 0;
    while (done !== 1'b1 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check("chain_done_seen", (g < 2000), 1);
    send_pulse();
    scenario_end("chain");
    check("chain_zero_gap", (rx_t.size() > 0) ? rx_t[$] - rx_t[0] : -1,
          (exp_q.size() - 1) * ByteCyc);

    // Randomized frames
    for (int it = 0; it < 8; it++) begin
      scenario_begin();
      n = $urandom_range(0, 5);
      for (int j = 0; j < n; j++) push(8'($urandom));
      check($sformatf("rnd%0d_full", it), full, (m_fifo.size() == Depth));
      send_pulse();
      scenario_end($sformatf("rnd%0d", it));
    end

    // Reset mid-payload
    scenario_begin();
    push(8'h5A);
    push(8'hC3);
    push(8'h7E);
    send_pulse();
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_full", full, 0);
    check("midrst_done", done, 0);
    m_fifo.delete();
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    scenario_begin();
    t0 = txlow_cnt;
    send_pulse();
    repeat (100) @(negedge clk);
    scenario_end("post_rst_send");
    check("post_rst_tx_low", txlow_cnt - t0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
